// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and its interpreter neighbour:
// jump-select encodings, the halt opcode and the fetch state encoding.
package cpu_pkg;

  localparam logic [1:0] JMP_SEQ = 2'd0;
  localparam logic [1:0] JMP_REL = 2'd1;
  localparam logic [1:0] JMP_REG = 2'd2;
  localparam logic [1:0] JMP_ABS = 2'd3;

  localparam logic [5:0] OP_HALT = 6'd0;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_ISSUE = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [1:0] ST_REQ   = FS_REQ;
  localparam logic [1:0] ST_ISSUE = FS_ISSUE;
  localparam logic [1:0] ST_HALT  = FS_HALT;

  // Word offset from a signed 16-bit immediate, scaled to bytes.
  function automatic logic [31:0] rel_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from the interpreter's jump encoding,
// with detection of a misaligned register jump target.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_jump_sel,
  input  logic        i_branch_taken,
  input  logic [31:0] i_jump_reg_val,
  input  logic [15:0] i_jump_imm16,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  logic [31:0] w_seq_pc;

  assign w_seq_pc = i_pc + 32'd4;

  always_comb begin
    o_next_pc  = w_seq_pc;
    o_misalign = 1'b0;
    case (i_jump_sel)
      JMP_SEQ: o_next_pc = w_seq_pc;
      JMP_REL: begin
        if (i_branch_taken) o_next_pc = i_pc + rel_offset(i_jump_imm16);
      end
      // Low address bits are forced to zero; the caller decides whether to flag it.
      JMP_REG: begin
        o_next_pc  = {i_jump_reg_val[31:2], 2'b00};
        o_misalign = |i_jump_reg_val[1:0];
      end
      JMP_ABS: o_next_pc = {i_pc[31:18], i_jump_imm16, 2'b00};
      default: o_next_pc = w_seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch: owns the PC, fetches over req/ack, holds the
// word for the interpreter and advances the PC when execution completes.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic [31:0]      pc_out,
  input  logic             exec_done,
  input  logic [1:0]       jump_sel,
  input  logic             branch_taken,
  input  logic [31:0]      jump_reg_val,
  input  logic [15:0]      jump_imm16,
  input  logic             pc_enable,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_halted;
  logic             r_misalign;
  logic [CNT_W-1:0] r_retired;

  logic [31:0]      w_next_pc;
  logic             w_misalign;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  next_pc_calc u_next_pc (
    .i_pc           (r_pc),
    .i_jump_sel     (jump_sel),
    .i_branch_taken (branch_taken),
    .i_jump_reg_val (jump_reg_val),
    .i_jump_imm16   (jump_imm16),
    .o_next_pc      (w_next_pc),
    .o_misalign     (w_misalign)
  );

  // Request is masked during reset so an in-flight handshake is visibly dropped.
  assign imem_req    = (r_state == ST_REQ) && !rst;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign instr_out   = r_instr;
  assign pc_out      = r_pc;
  assign halted      = r_halted;
  assign misalign    = r_misalign;
  assign retired     = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            r_retired <= sat_inc(r_retired);
            if (!pc_enable) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc       <= w_next_pc;
              r_misalign <= w_misalign;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a behavioural memory
// and next-PC model; a monitor checks every presented instruction.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 4;
  localparam int          MAXR     = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_t;

  logic             clk;
  logic             rst;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr_out;
  logic             instr_valid;
  logic [31:0]      pc_out;
  logic             exec_done;
  logic [1:0]       jump_sel;
  logic             branch_taken;
  logic [31:0]      jump_reg_val;
  logic [15:0]      jump_imm16;
  logic             pc_enable;
  logic             halted;
  logic             misalign;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  fetch_t      exp_q[$];
  fetch_t      cur;
  bit          have_cur = 0;

  logic [31:0] pc_m;
  int          ret_m;
  int          force_wait = 0;
  int          last_wait = 0;
  bit          ack_now = 0;
  bit          noise = 0;

  int          r_sel;
  bit          r_taken;
  logic [31:0] r_regv;
  logic [15:0] r_imm;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out),
    .exec_done(exec_done), .jump_sel(jump_sel), .branch_taken(branch_taken),
    .jump_reg_val(jump_reg_val), .jump_imm16(jump_imm16), .pc_enable(pc_enable),
    .halted(halted), .misalign(misalign), .retired(retired)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference next-PC from the architectural rules, plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input int sel, input bit taken,
                                             input logic [31:0] regv, input logic [15:0] imm);
    int off;
    case (sel)
      0: return pc + 32'd4;
      1: begin
        if (!taken) return pc + 32'd4;
        off = int'($signed(imm)) * 4;
        return pc + 32'(off);
      end
      2: return regv & 32'hFFFF_FFFC;
      default: return (pc & 32'hFFFC_0000) | (32'(imm) << 2);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Memory responder: acks after a chosen number of wait cycles.
  initial begin
    int  w;
    bit  active;
    w = 0;
    active = 0;
    imem_ack = 0;
    imem_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 0;
      if (ack_now) begin
        imem_ack = 1;
        imem_rdata = $urandom;
        ack_now = 0;
        active = 0;
      end else if (imem_req) begin
        if (!active) begin
          active = 1;
          w = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
          last_wait = w;
        end
        if (w == 0) begin
          imem_ack = 1;
          imem_rdata = get_word(imem_addr);
          active = 0;
        end else begin
          w--;
        end
      end else begin
        active = 0;
        if (noise && ($urandom_range(0, 3) == 0)) begin
          imem_ack = 1;
          imem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: each newly presented instruction is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 0;
      end else if (instr_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_issue actual pc=%h required=none", pc_out);
          end else begin
            cur = exp_q.pop_front();
          end
          have_cur = 1;
        end
        chk("mon_instr_out", instr_out, cur.word);
        chk("mon_pc_out", pc_out, cur.pc);
      end else begin
        have_cur = 0;
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_pc_out", pc_out, RESET_PC);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_retired", 32'(retired), 0);
    exp_q.delete();
    pc_m = RESET_PC;
    ret_m = 0;
    exp_q.push_back('{RESET_PC, get_word(RESET_PC)});
    rst = 0;
    #1;
  endtask

  task automatic wait_issue();
    int req_cnt;
    int guard;
    bit mchk;
    req_cnt = 0;
    guard = 0;
    mchk = 0;
    while (!instr_valid && guard < 50) begin
      if (imem_req) begin
        req_cnt++;
        chk("imem_addr", imem_addr, pc_m);
      end
      if (noise) begin
        exec_done = 1'($urandom_range(0, 1));
        jump_sel = 2'($urandom);
        pc_enable = 1'($urandom);
      end
      @(posedge clk);
      #1;
      guard++;
      if (!mchk) begin
        chk("misalign_clear", 32'(misalign), 0);
        mchk = 1;
      end
    end
    exec_done = 0;
    pc_enable = 1;
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=no_valid required=valid_within_50");
    end else begin
      chk("req_cycles", 32'(req_cnt), 32'(last_wait + 1));
    end
  endtask

  task automatic exec_instr(input int sel, input bit taken, input logic [31:0] regv,
                            input logic [15:0] imm, input bit pen, input int hold);
    logic [31:0] npc;
    bit          mis_e;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    exec_done = 1;
    jump_sel = 2'(sel);
    branch_taken = taken;
    jump_reg_val = regv;
    jump_imm16 = imm;
    pc_enable = pen;
    npc = model_next(pc_m, sel, taken, regv, imm);
    mis_e = (sel == 2) && (regv[1:0] != 2'b00);
    @(posedge clk);
    #1;
    exec_done = 0;
    pc_enable = 1;
    ret_m = (ret_m == MAXR) ? ret_m : ret_m + 1;
    chk("retired", 32'(retired), 32'(ret_m));
    if (!pen) begin
      chk("halt_halted", 32'(halted), 1);
      chk("halt_imem_req", 32'(imem_req), 0);
      chk("halt_instr_valid", 32'(instr_valid), 0);
      chk("halt_pc_kept", pc_out, pc_m);
    end else begin
      pc_m = npc;
      exp_q.push_back('{npc, get_word(npc)});
      chk("next_pc", pc_out, npc);
      chk("misalign", 32'(misalign), 32'(mis_e));
      chk("not_halted", 32'(halted), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    exec_done = 0;
    jump_sel = 0;
    branch_taken = 0;
    jump_reg_val = 0;
    jump_imm16 = 0;
    pc_enable = 1;
    mem[32'h0] = 32'h0441_0000;

    force_wait = 0;
    do_reset(3);
    wait_issue();
    chk("first_pc_out", pc_out, 32'h0);
    exec_instr(0, 0, 32'h0, 16'h0, 1, 0);

    force_wait = 3;
    wait_issue();
    exec_instr(3, 0, 32'h0, 16'h0040, 1, 2);
    force_wait = 0;
    wait_issue();
    exec_instr(1, 1, 32'h0, 16'hFFFE, 1, 0);
    wait_issue();
    exec_instr(2, 0, 32'h0000_0100, 16'h0, 1, 0);
    wait_issue();
    exec_instr(1, 0, 32'h0, 16'hFFFE, 1, 0);
    wait_issue();
    exec_instr(1, 1, 32'h0, 16'h0000, 1, 1);
    wait_issue();
    exec_instr(2, 0, 32'h8000_0010, 16'h0, 1, 0);
    wait_issue();
    exec_instr(3, 0, 32'h0, 16'h1234, 1, 0);
    wait_issue();
    chk("abs_target", pc_out, 32'h8000_48D0);
    exec_instr(2, 0, 32'h8000_0010, 16'h0, 1, 0);
    wait_issue();
    exec_instr(2, 0, 32'h0000_0203, 16'h0, 1, 0);
    wait_issue();
    exec_instr(2, 0, 32'hFFFF_FFFC, 16'h0, 1, 0);
    wait_issue();
    exec_instr(0, 0, 32'h0, 16'h0, 1, 0);
    wait_issue();
    chk("wrap_pc", pc_out, 32'h0);

    force_wait = -1;
    noise = 1;
    repeat (150) begin
      r_sel = $urandom_range(0, 3);
      r_taken = 1'($urandom_range(0, 1));
      r_regv = $urandom;
      if ($urandom_range(0, 1) == 1) r_regv[1:0] = 2'b00;
      r_imm = 16'($urandom);
      exec_instr(r_sel, r_taken, r_regv, r_imm, 1, $urandom_range(0, 2));
      wait_issue();
    end

    exec_instr($urandom_range(0, 3), 1, 32'h40, 16'h10, 0, 1);
    repeat (20) begin
      exec_done = 1'($urandom_range(0, 1));
      pc_enable = 1'($urandom);
      @(posedge clk);
      #1;
      chk("halt_hold_req", 32'(imem_req), 0);
      chk("halt_hold_valid", 32'(instr_valid), 0);
      chk("halt_hold_flag", 32'(halted), 1);
      chk("halt_hold_retired", 32'(retired), 32'(ret_m));
    end
    exec_done = 0;
    pc_enable = 1;

    do_reset(2);
    wait_issue();
    repeat (3) begin
      exec_instr($urandom_range(0, 3), 1'($urandom), $urandom, 16'($urandom), 1, 0);
      wait_issue();
    end

    force_wait = 10;
    exec_instr(2, 0, 32'h0000_0040, 16'h0, 1, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    force_wait = -1;
    ack_now = 1;
    do_reset(1);
    wait_issue();
    repeat (3) begin
      exec_instr($urandom_range(0, 3), 1'($urandom), $urandom, 16'($urandom), 1, 1);
      wait_issue();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
